mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port synchronous data/instruction RAM.
- Port 0 is the multicycle core, which issues both fetch and load/store accesses. Port 1 is the program loader / debug master.
- Per-access round-robin arbitration with an optional port-1 lock for bulk loading.
- Registered response path matched to the RAM's one-cycle read latency, plus alignment and range error checking.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous RAM: round-robin per access,
// optional port-1 lock for bulk loads, one-cycle registered response with fault reporting.

module mem_arbiter_port #(
    parameter int ADDR_W = 10
) (
    input  logic [31:0]       addr,
    input  logic              rsp_hit,
    input  logic              rsp_write,
    input  logic              rsp_fault,
    input  logic [31:0]       mem_data_out,
    output logic              fault,
    output logic [ADDR_W-1:0] word,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    assign word      = addr[ADDR_W+1:2];
    assign fault     = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    assign rsp_valid = rsp_hit;
    assign rsp_rdata = (rsp_hit && !rsp_write && !rsp_fault) ? mem_data_out : 32'd0;
    assign rsp_err   = rsp_hit & rsp_fault;
endmodule

module mem_arbiter #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_write,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_write,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    input  logic              p1_lock,
    output logic              core_stall,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);
    localparam int NUM_PORTS = 2;

    typedef enum logic {FREE = 1'b0, LOCKED1 = 1'b1} lock_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    lock_t state, state_next;
    logic  rr_last;
    logic  rsp_vld, rsp_port, rsp_write, rsp_fault;

    req_t [NUM_PORTS-1:0]              req;
    logic [NUM_PORTS-1:0]              valid, ready, fault, rsp_hit, rsp_valid, rsp_err;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  word;
    logic [NUM_PORTS-1:0][31:0]        rsp_rdata;
    logic                              any_grant, gsel;

    assign valid  = {p1_valid, p0_valid};
    assign req[0] = '{write: p0_write, addr: p0_addr, wdata: p0_wdata};
    assign req[1] = '{write: p1_write, addr: p1_addr, wdata: p1_wdata};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            // Reset drops a response that is due in the reset cycle itself.
            assign rsp_hit[i] = rsp_vld & ~reset & (rsp_port == 1'(i));
            mem_arbiter_port #(.ADDR_W(ADDR_W)) u_port (
                .addr        (req[i].addr),
                .rsp_hit     (rsp_hit[i]),
                .rsp_write   (rsp_write),
                .rsp_fault   (rsp_fault),
                .mem_data_out(mem_data_out),
                .fault       (fault[i]),
                .word        (word[i]),
                .rsp_valid   (rsp_valid[i]),
                .rsp_rdata   (rsp_rdata[i]),
                .rsp_err     (rsp_err[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) state <= FREE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE:    if (ready[1] && p1_lock) state_next = LOCKED1;
            LOCKED1: if (!p1_lock)            state_next = FREE;
            default: state_next = FREE;
        endcase
    end

    // Grant: lock excludes port 0; on contention the port that did not win last goes.
    always_comb begin
        ready = '0;
        if (state == LOCKED1)          ready[1] = valid[1];
        else if (valid[0] && valid[1]) ready    = rr_last ? 2'b01 : 2'b10;
        else                           ready    = valid;
    end

    assign any_grant = |ready;
    assign gsel      = ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last   <= 1'b1;
            rsp_vld   <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_write <= 1'b0;
            rsp_fault <= 1'b0;
        end else begin
            if (any_grant) rr_last <= gsel;
            rsp_vld   <= any_grant;
            rsp_port  <= gsel;
            rsp_write <= any_grant & req[gsel].write;
            rsp_fault <= any_grant & fault[gsel];
        end
    end

    always_comb begin
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_data_in      = '0;
        if (any_grant) begin
            mem_write_enable = req[gsel].write & ~fault[gsel];
            mem_addr         = word[gsel];
            mem_data_in      = req[gsel].wdata;
        end
    end

    assign p0_ready     = ready[0];
    assign p1_ready     = ready[1];
    assign core_stall   = p0_valid & ~ready[0];
    assign p0_rsp_valid = rsp_valid[0];
    assign p0_rsp_rdata = rsp_rdata[0];
    assign p0_rsp_err   = rsp_err[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p1_rsp_rdata = rsp_rdata[1];
    assign p1_rsp_err   = rsp_err[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: rule-level predictor, response monitor, bench-side RAM,
// directed scenarios followed by a randomized phase.

module tb_mem_arbiter;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              p0_valid = 0, p0_write = 0, p1_valid = 0, p1_write = 0, p1_lock = 0;
    logic [31:0]       p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic              p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [31:0]       p0_rsp_rdata, p1_rsp_rdata;
    logic              core_stall, mem_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .p1_lock(p1_lock), .core_stall(core_stall),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ 32'h1234_5678;
    endfunction

    // Bench-side RAM: one-cycle read latency, write commits at the edge.
    logic [31:0] ram [DEPTH];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else begin
            if (mem_write_enable) ram[mem_addr] <= mem_data_in;
            mem_data_out <= ram[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_mem [DEPTH];

    // Predictor: grant/memory expectations from the arbitration rules, response pushed to sb.
    initial begin
        bit          m_locked;
        bit          m_rr;
        int          g;
        logic [31:0] a, wd, rd;
        logic        wr, flt;
        int          idx;
        m_locked = 0;
        m_rr     = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            g = -1;
            if (m_locked)                   g = p1_valid ? 1 : -1;
            else if (p0_valid && p1_valid)  g = m_rr ? 0 : 1;
            else if (p0_valid)              g = 0;
            else if (p1_valid)              g = 1;
            check("p0_ready", p0_ready, g == 0);
            check("p1_ready", p1_ready, g == 1);
            check("core_stall", core_stall, p0_valid && g != 0);
            if (g >= 0) begin
                a   = (g == 1) ? p1_addr  : p0_addr;
                wd  = (g == 1) ? p1_wdata : p0_wdata;
                wr  = (g == 1) ? p1_write : p0_write;
                flt = (a % 4 != 0) || (a > 32'(4 * DEPTH - 1));
                idx = int'((a / 4) % DEPTH);
                check("mem_we", mem_write_enable, wr && !flt);
                check("mem_addr", 32'(mem_addr), 32'(idx));
                check("mem_data_in", mem_data_in, wd);
                rd = (wr || flt) ? 32'd0 : ref_mem[idx];
                if (!reset) sb.push_back('{g, cyc + 1, rd, flt});
                if (wr && !flt) ref_mem[idx] = wd;
            end else begin
                check("idle_mem_we", mem_write_enable, 0);
                check("idle_mem_addr", 32'(mem_addr), 0);
                check("idle_mem_data_in", mem_data_in, 0);
            end
            if (reset) begin
                m_locked = 0;
                m_rr     = 1;
            end else begin
                if (g >= 0) m_rr = (g == 1);
                if (m_locked)                  m_locked = p1_lock;
                else if (g == 1 && p1_lock)    m_locked = 1;
            end
        end
    end

    // Monitor: pops the response due this cycle and compares what each port presents.
    initial begin
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            have = 0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("sb_due", e.due, cyc);
                have = !reset;
            end
            check("p0_rsp_valid", p0_rsp_valid, have && e.port == 0);
            check("p1_rsp_valid", p1_rsp_valid, have && e.port == 1);
            if (have && e.port == 0) begin
                check("p0_rsp_rdata", p0_rsp_rdata, e.rdata);
                check("p0_rsp_err", p0_rsp_err, e.err);
            end else check("p0_rsp_err_idle", p0_rsp_err, 0);
            if (have && e.port == 1) begin
                check("p1_rsp_rdata", p1_rsp_rdata, e.rdata);
                check("p1_rsp_err", p1_rsp_err, e.err);
            end else check("p1_rsp_err_idle", p1_rsp_err, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, required completion before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_valid = 0; p1_valid = 0; p0_write = 0; p1_write = 0; p1_lock = 0;
    endtask

    task automatic req0(logic w, logic [31:0] a, logic [31:0] d);
        p0_valid = 1; p0_write = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic req1(logic w, logic [31:0] a, logic [31:0] d);
        p1_valid = 1; p1_write = w; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        int lock_burst;
        int diffs;
        repeat (3) tick();
        #1 check("reset_p0_rsp_valid", p0_rsp_valid, 0);
        check("reset_mem_we", mem_write_enable, 0);
        reset = 0;

        // Single-port read of RAM[4]
        req0(0, 32'h10, 0);
        #1 check("dir_rd_ready", p0_ready, 1);
        check("dir_rd_mem_addr", 32'(mem_addr), 4);
        tick(); idle();
        #1 check("dir_rd_rdata", p0_rsp_rdata, 32'hDEADBEEF);
        check("dir_rd_p1_quiet", p1_rsp_valid, 0);
        tick();

        // Contention right after reset: p0, p1, p0, p1
        reset = 1; tick(); reset = 0;
        req0(0, 32'h40, 0); req1(0, 32'h80, 0);
        for (int k = 0; k < 4; k++) begin
            #1 check("dir_rr_p0_ready", p0_ready, (k % 2) == 0);
            check("dir_rr_stall", core_stall, (k % 2) == 1);
            tick();
        end
        idle();

        // Lock: p0 runs alone first so p1 wins the first contested write
        req0(0, 32'h0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            req0(0, 32'h4, 0);
            req1(1, 32'(4 * k), 32'(k + 1)); p1_lock = 1;
            #1 check("dir_lock_p0_ready", p0_ready, 0);
            check("dir_lock_stall", core_stall, 1);
            tick();
        end
        p1_valid = 0; p1_write = 0; p1_lock = 0;
        #1 check("dir_unlock_cycle_p0_ready", p0_ready, 0);
        tick();
        #1 check("dir_after_unlock_p0_ready", p0_ready, 1);
        tick(); idle();
        #1 check("dir_lock_readback", p0_rsp_rdata, 2);
        tick();

        // Faults: misaligned write, out-of-range read
        req0(1, 32'h6, 32'hFFFF_FFFF);
        #1 check("dir_misaligned_we", mem_write_enable, 0);
        tick(); idle();
        req1(0, 32'h1000, 0);
        #1 check("dir_misaligned_err", p0_rsp_err, 1);
        check("dir_misaligned_rdata", p0_rsp_rdata, 0);
        tick(); idle();
        #1 check("dir_range_err", p1_rsp_err, 1);
        check("dir_ram_unchanged", ram[1], 2);
        tick();

        // Write then read the same word on consecutive cycles
        req1(1, 32'h20, 32'hA5A5A5A5); tick(); idle();
        req0(0, 32'h20, 0); tick(); idle();
        #1 check("dir_wr_rd", p0_rsp_rdata, 32'hA5A5A5A5);
        tick();

        // Reset the cycle after a p0 read is accepted
        req0(0, 32'h10, 0); tick(); idle();
        reset = 1; req1(0, 32'h0, 0); p1_lock = 1;
        #1 check("dir_rst_drop", p0_rsp_valid, 0);
        tick(); reset = 0;
        req0(0, 32'h8, 0); req1(0, 32'hC, 0); p1_lock = 1;
        #1 check("dir_rst_no_rsp", p0_rsp_valid, 0);
        check("dir_rst_p0_wins", p0_ready, 1);
        tick(); idle(); tick();

        // Randomized traffic
        lock_burst = 0;
        for (int n = 0; n < 3000; n++) begin
            p0_valid = ($urandom_range(0, 9) < 6);
            p1_valid = ($urandom_range(0, 9) < 5);
            p0_write = $urandom_range(0, 9) < 4;
            p1_write = $urandom_range(0, 9) < 4;
            p0_wdata = $urandom;
            p1_wdata = $urandom;
            case ($urandom_range(0, 19))
                0:       p0_addr = $urandom;
                1:       p0_addr = 32'($urandom_range(0, 63)) | 32'h1;
                default: p0_addr = 32'($urandom_range(0, 15)) * 4;
            endcase
            case ($urandom_range(0, 19))
                0:       p1_addr = $urandom | 32'h1000;
                1:       p1_addr = 32'($urandom_range(0, 63)) | 32'h2;
                default: p1_addr = 32'($urandom_range(0, 15)) * 4;
            endcase
            if (lock_burst > 0) lock_burst--;
            else if ($urandom_range(0, 19) == 0) lock_burst = $urandom_range(1, 8);
            p1_lock = (lock_burst > 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0; idle();
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check("ram_contents", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
